tank_refill_controller: RTL and testbench

//   Supply end of the irrigation water path: refills the tank the dripper draws from.

---
 rtl/tank_refill_controller_pkg.sv | 30 +++
 rtl/level_debouncer.sv | 55 +++++
 rtl/tank_refill_controller.sv | 163 ++++++++++++++++
 tb/tb_tank_refill_controller.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/tank_refill_controller_pkg.sv
// ---------------------------------------------------------------------------
// tank_refill_controller_pkg
//   Shared definitions for the tank refill controller: FSM state encodings,
//   default timing constants and the probe-consistency helper.
//   No ports (package).
// ---------------------------------------------------------------------------
package tank_refill_controller_pkg;

    // State encodings are fixed so that other irrigation blocks and debug
    // tooling can decode the controller state directly.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILLING = 2'd1,
        SETTLE  = 2'd2,
        FAULT   = 2'd3
    } state_e;

    // Default timing constants.
    localparam int DEF_DEBOUNCE_CYCLES = 8;
    localparam int DEF_FILL_TIMEOUT    = 1000;
    localparam int DEF_SETTLE_CYCLES   = 16;
    localparam int DEF_CNT_W           = 16;

    // Water can only reach a probe if every probe below it is also wet:
    // high implies mid, mid implies low. Anything else is a probe fault.
    function automatic logic level_valid(input logic low, input logic mid, input logic high);
        return (!high || mid) && (!mid || low);
    endfunction

endpackage

// File: rtl/level_debouncer.sv
// ---------------------------------------------------------------------------
// level_debouncer
//   Debounces one raw tank level probe. The debounced value follows the raw
//   value only after the raw value has differed from it for DEBOUNCE_CYCLES
//   consecutive cycles; any return to agreement restarts the count.
//   Ports:
//     clk      in  system clock, rising edge
//     reset_n  in  asynchronous active-low reset (debounced value -> 0)
//     raw      in  raw probe input
//     stable   out registered debounced probe value
// ---------------------------------------------------------------------------
module level_debouncer #(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic stable
);

    localparam int            CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;

    // The counter holds the number of disagreeing cycles already seen; on the
    // cycle it sits at LAST the disagreement is the DEBOUNCE_CYCLES-th one, so
    // the debounced value flips on that edge.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (raw == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            stable_d = raw;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/tank_refill_controller.sv
// ---------------------------------------------------------------------------
// tank_refill_controller
//   Refills the tank that feeds the drip irrigation. Debounces the low, mid
//   and high probes, opens the inlet valve when the level falls below mid,
//   closes it at high and keeps it closed for a settle window. Inconsistent
//   probe patterns and overlong fills latch sticky faults that need an
//   explicit clear.
//   Ports:
//     clk               in  system clock, rising edge
//     reset_n           in  asynchronous active-low reset
//     low_water_level   in  raw probe, 1 = water at low mark
//     mid_water_level   in  raw probe, 1 = water at mid mark
//     high_water_level  in  raw probe, 1 = water at high mark
//     enable            in  refill permitted
//     fault_clear       in  one-cycle request to leave FAULT
//     inlet_valve       out 1 = inlet open
//     filling           out 1 while in FILLING (same as inlet_valve)
//     level_fault       out sticky inconsistent-probe flag
//     timeout_fault     out sticky fill-timeout flag
//     stable_mid_level  out debounced mid probe
// ---------------------------------------------------------------------------
module tank_refill_controller
    import tank_refill_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int FILL_TIMEOUT    = DEF_FILL_TIMEOUT,
    parameter int SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset_n,
    input  logic low_water_level,
    input  logic mid_water_level,
    input  logic high_water_level,
    input  logic enable,
    input  logic fault_clear,
    output logic inlet_valve,
    output logic filling,
    output logic level_fault,
    output logic timeout_fault,
    output logic stable_mid_level
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(FILL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMER_MAX    = '1;

    logic low_s, mid_s, high_s;
    logic levels_ok;

    state_e           state_q;
    logic [CNT_W-1:0] timer_q;
    logic [CNT_W-1:0] timer_inc;
    logic             valve_q;
    logic             level_fault_q;
    logic             timeout_fault_q;

    level_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_low_db (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (low_water_level),
        .stable  (low_s)
    );

    level_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mid_db (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (mid_water_level),
        .stable  (mid_s)
    );

    level_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_high_db (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (high_water_level),
        .stable  (high_s)
    );

    assign levels_ok = level_valid(low_s, mid_s, high_s);

    // Saturating increment so a stuck state can never wrap the timer back
    // into a range that looks like a fresh fill.
    assign timer_inc = (timer_q == TIMER_MAX) ? timer_q : timer_q + CNT_W'(1);

    // Refill FSM. Valve and fault flags are registered alongside the state so
    // they change on the same edge as the transition that causes them. In
    // FILLING the checks are ordered so a probe fault beats a timeout, and a
    // timeout beats reaching high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            timer_q         <= '0;
            valve_q         <= 1'b0;
            level_fault_q   <= 1'b0;
            timeout_fault_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    valve_q <= 1'b0;
                    if (!levels_ok) begin
                        state_q       <= FAULT;
                        level_fault_q <= 1'b1;
                    end else if (enable && !mid_s) begin
                        state_q <= FILLING;
                        timer_q <= '0;
                        valve_q <= 1'b1;
                    end
                end
                FILLING: begin
                    if (!levels_ok) begin
                        state_q       <= FAULT;
                        valve_q       <= 1'b0;
                        level_fault_q <= 1'b1;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        state_q         <= FAULT;
                        valve_q         <= 1'b0;
                        timeout_fault_q <= 1'b1;
                    end else if (high_s) begin
                        state_q <= SETTLE;
                        timer_q <= '0;
                        valve_q <= 1'b0;
                    end else if (!enable) begin
                        state_q <= IDLE;
                        valve_q <= 1'b0;
                    end else begin
                        timer_q <= timer_inc;
                        valve_q <= 1'b1;
                    end
                end
                SETTLE: begin
                    valve_q <= 1'b0;
                    if (!levels_ok) begin
                        state_q       <= FAULT;
                        level_fault_q <= 1'b1;
                    end else if (timer_q == SETTLE_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        timer_q <= timer_inc;
                    end
                end
                FAULT: begin
                    valve_q <= 1'b0;
                    if (fault_clear && levels_ok) begin
                        state_q         <= IDLE;
                        level_fault_q   <= 1'b0;
                        timeout_fault_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valve_q <= 1'b0;
                end
            endcase
        end
    end

    assign inlet_valve      = valve_q;
    assign filling          = valve_q;
    assign level_fault      = level_fault_q;
    assign timeout_fault    = timeout_fault_q;
    assign stable_mid_level = mid_s;

endmodule

// File: tb/tb_tank_refill_controller.sv
// ---------------------------------------------------------------------------
// tb_tank_refill_controller
//   Directed self-checking bench for tank_refill_controller with short timing
//   parameters (debounce 4, timeout 20, settle 3). Inputs change 1 time unit
//   after a rising edge and outputs are sampled at the same point, so "edge N"
//   below is the N-th rising edge after reset release.
// ---------------------------------------------------------------------------
module tb_tank_refill_controller;
    import tank_refill_controller_pkg::*;

    localparam int DB = 4;
    localparam int FT = 20;
    localparam int SC = 3;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic resetN;
    logic lowLevel, midLevel, highLevel, enableIn, faultClear;
    logic inletValve, fillingOut, levelFault, timeoutFault, stableMid;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    tank_refill_controller #(
        .DEBOUNCE_CYCLES (DB),
        .FILL_TIMEOUT    (FT),
        .SETTLE_CYCLES   (SC),
        .CNT_W           (CW)
    ) dut (
        .clk              (clk),
        .reset_n          (resetN),
        .low_water_level  (lowLevel),
        .mid_water_level  (midLevel),
        .high_water_level (highLevel),
        .enable           (enableIn),
        .fault_clear      (faultClear),
        .inlet_valve      (inletValve),
        .filling          (fillingOut),
        .level_fault      (levelFault),
        .timeout_fault    (timeoutFault),
        .stable_mid_level (stableMid)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic l, input logic m, input logic h, input logic en, input logic clr);
        lowLevel   = l;
        midLevel   = m;
        highLevel  = h;
        enableIn   = en;
        faultClear = clr;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds reset across two falling edges with the given inputs applied, then
    // releases it on a falling edge so the next rising edge is edge 1.
    task automatic pulseReset(input logic l, input logic m, input logic h, input logic en);
        applyStimulus(l, m, h, en, 1'b0);
        resetN = 1'b0;
        repeat (2) @(negedge clk);
        resetN = 1'b1;
    endtask

    initial begin
        resetN = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // ---- Test 1: reset state and a normal fill ----
        $display("[TB] test 1: normal fill");
        @(negedge clk);
        checkOutput("rst_valve",   32'(inletValve),   32'd0);
        checkOutput("rst_filling", 32'(fillingOut),   32'd0);
        checkOutput("rst_lfault",  32'(levelFault),   32'd0);
        checkOutput("rst_tfault",  32'(timeoutFault), 32'd0);
        checkOutput("rst_smid",    32'(stableMid),    32'd0);
        checkOutput("rst_state",   32'(dut.state_q),  32'(IDLE));
        pulseReset(1'b1, 1'b0, 1'b0, 1'b1);
        tick(1);                                    // edge 1
        checkOutput("t1_valve_open", 32'(inletValve), 32'd1);
        checkOutput("t1_filling",    32'(fillingOut), 32'd1);
        tick(4);                                    // edge 5
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(3);                                    // edge 8
        checkOutput("t1_smid_before", 32'(stableMid), 32'd0);
        tick(1);                                    // edge 9
        checkOutput("t1_smid_after",  32'(stableMid),  32'd1);
        checkOutput("t1_valve_mid",   32'(inletValve), 32'd1);
        tick(1);                                    // edge 10
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(4);                                    // edge 14: high debounced
        checkOutput("t1_valve_hi_db", 32'(inletValve), 32'd1);
        tick(1);                                    // edge 15: FSM sees high
        checkOutput("t1_valve_closed", 32'(inletValve),  32'd0);
        checkOutput("t1_settle_entry", 32'(dut.state_q), 32'(SETTLE));
        tick(2);                                    // edge 17
        checkOutput("t1_settle_last",  32'(dut.state_q), 32'(SETTLE));
        tick(1);                                    // edge 18
        checkOutput("t1_idle_after",   32'(dut.state_q), 32'(IDLE));
        checkOutput("t1_valve_idle",   32'(inletValve),  32'd0);

        // ---- Test 2: bouncing mid/high probes while filling ----
        $display("[TB] test 2: bounce");
        pulseReset(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1);                                    // edge 1
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, ~i[0], ~i[0], 1'b1, 1'b0);
            tick(2);
            checkOutput($sformatf("t2_valve_%0d", i), 32'(inletValve), 32'd1);
            checkOutput($sformatf("t2_smid_%0d", i),  32'(stableMid),  32'd0);
        end

        // ---- Test 3: fill timeout and recovery ----
        $display("[TB] test 3: timeout");
        pulseReset(1'b1, 1'b0, 1'b0, 1'b1);
        tick(1);                                    // edge 1
        checkOutput("t3_valve_open", 32'(inletValve), 32'd1);
        tick(19);                                   // edge 20
        checkOutput("t3_valve_last", 32'(inletValve),   32'd1);
        checkOutput("t3_tfault_pre", 32'(timeoutFault), 32'd0);
        tick(1);                                    // edge 21
        checkOutput("t3_tfault",     32'(timeoutFault), 32'd1);
        checkOutput("t3_valve_shut", 32'(inletValve),   32'd0);
        checkOutput("t3_lfault",     32'(levelFault),   32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(1);                                    // edge 22
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t3_tfault_clr", 32'(timeoutFault), 32'd0);
        checkOutput("t3_idle",       32'(dut.state_q),  32'(IDLE));
        tick(1);                                    // edge 23
        checkOutput("t3_refill",     32'(inletValve),   32'd1);

        // ---- Test 4: inconsistent probes, enable low ----
        $display("[TB] test 4: inconsistent probes");
        pulseReset(1'b1, 1'b0, 1'b1, 1'b0);
        tick(1);                                    // edge 1
        checkOutput("t4_enable_low", 32'(inletValve), 32'd0);
        tick(3);                                    // edge 4: 101 debounced
        checkOutput("t4_lfault_pre", 32'(levelFault), 32'd0);
        tick(1);                                    // edge 5
        checkOutput("t4_lfault",     32'(levelFault), 32'd1);
        checkOutput("t4_valve",      32'(inletValve), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        tick(2);                                    // edge 7
        checkOutput("t4_clr_ignored", 32'(levelFault), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        tick(4);                                    // edge 11: mid debounced
        checkOutput("t4_still_fault", 32'(levelFault), 32'd1);
        tick(1);                                    // edge 12
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("t4_cleared",     32'(levelFault),  32'd0);
        checkOutput("t4_idle",        32'(dut.state_q), 32'(IDLE));

        // ---- Test 5: enable drop and reset mid-fill ----
        $display("[TB] test 5: enable and reset mid-fill");
        pulseReset(1'b0, 1'b0, 1'b0, 1'b1);
        tick(3);                                    // edge 3
        checkOutput("t5_filling", 32'(inletValve), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);                                    // edge 4
        checkOutput("t5_en_drop_valve", 32'(inletValve),  32'd0);
        checkOutput("t5_en_drop_state", 32'(dut.state_q), 32'(IDLE));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1);                                    // edge 5
        checkOutput("t5_reopen", 32'(inletValve), 32'd1);
        #2 resetN = 1'b0;
        #1;
        checkOutput("t5_async_valve",   32'(inletValve),   32'd0);
        checkOutput("t5_async_filling", 32'(fillingOut),   32'd0);
        checkOutput("t5_async_lfault",  32'(levelFault),   32'd0);
        checkOutput("t5_async_tfault",  32'(timeoutFault), 32'd0);

        // ---- Test 6a: high seen one cycle before timeout -> settle ----
        $display("[TB] test 6: high vs timeout");
        pulseReset(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1);                                    // edge 1
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(14);                                   // edge 15
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(4);                                    // edge 19: high debounced
        checkOutput("t6a_valve_pre", 32'(inletValve), 32'd1);
        tick(1);                                    // edge 20
        checkOutput("t6a_settle", 32'(dut.state_q),  32'(SETTLE));
        checkOutput("t6a_tfault", 32'(timeoutFault), 32'd0);
        checkOutput("t6a_valve",  32'(inletValve),   32'd0);

        // ---- Test 6b: high and timeout on the same cycle -> timeout ----
        pulseReset(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1);                                    // edge 1
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(15);                                   // edge 16
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(4);                                    // edge 20: high debounced, timer 19
        checkOutput("t6b_valve_pre", 32'(inletValve),   32'd1);
        checkOutput("t6b_tfault_pre", 32'(timeoutFault), 32'd0);
        tick(1);                                    // edge 21
        checkOutput("t6b_tfault", 32'(timeoutFault), 32'd1);
        checkOutput("t6b_state",  32'(dut.state_q),  32'(FAULT));
        checkOutput("t6b_valve",  32'(inletValve),   32'd0);
        checkOutput("t6b_lfault", 32'(levelFault),   32'd0);
        #2 resetN = 1'b0;
        #1;
        checkOutput("t6b_async_tfault", 32'(timeoutFault), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
